// File: rtl/char_sequencer.sv
// char_sequencer: produces the 6-bit character code (0..LAST_CODE) feeding the
// seven-segment decoder. Steps automatically at a prescaled rate in RUN, or
// once per rising edge of the manual step button in IDLE/HOLD. The direction
// is selectable (up/down), and a direct load is clamped to the valid ring.
//
// All control inputs are plain levels sampled on the rising edge of clk_2;
// there is no valid/ready handshake. load has priority over any advance.
module char_sequencer #(
  parameter int STEP_DIV  = 4,
  parameter int LAST_CODE = 41
) (
  input  logic       clk_2,
  input  logic       reset_n,
  input  logic       run,
  input  logic       dir,
  input  logic       step,
  input  logic       load,
  input  logic [5:0] load_code,
  output logic [5:0] code,
  output logic       wrap,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [5:0] LAST   = 6'(LAST_CODE);
  localparam logic [7:0] DIV_M1 = 8'(STEP_DIV - 1);

  state_t     cur_state;
  state_t     nxt_state;
  logic [7:0] cnt;
  logic [7:0] cnt_nxt;
  logic       step_q;
  logic [5:0] code_nxt;
  logic       wrap_nxt;
  logic       advance;

  // Next-state, prescaler, step detect and code update for the coming edge.
  always_comb begin
    nxt_state = cur_state;
    cnt_nxt   = 8'd0;
    advance   = 1'b0;
    code_nxt  = code;
    wrap_nxt  = 1'b0;

    case (cur_state)
      IDLE:    if (run) nxt_state = RUN;
      RUN:     if (!run) nxt_state = HOLD;
      HOLD:    if (run) nxt_state = RUN;
      default: nxt_state = IDLE;
    endcase

    // Prescaler only counts while staying in RUN; leaving RUN discards a
    // partially counted interval.
    if (cur_state == RUN && run) begin
      if (cnt == DIV_M1) begin
        advance = 1'b1;
        cnt_nxt = 8'd0;
      end else begin
        cnt_nxt = cnt + 8'd1;
      end
    end

    // Manual step edges are honoured outside RUN only.
    if (cur_state != RUN && step && !step_q) begin
      advance = 1'b1;
    end

    if (load) begin
      code_nxt = (load_code > LAST) ? LAST : load_code;
      cnt_nxt  = 8'd0;
    end else if (advance) begin
      if (!dir) begin
        if (code == LAST) begin
          code_nxt = 6'd0;
          wrap_nxt = 1'b1;
        end else begin
          code_nxt = code + 6'd1;
        end
      end else begin
        if (code == 6'd0) begin
          code_nxt = LAST;
          wrap_nxt = 1'b1;
        end else begin
          code_nxt = code - 6'd1;
        end
      end
    end
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk_2 or negedge reset_n) begin
    if (!reset_n) begin
      cur_state <= IDLE;
      cnt       <= 8'd0;
      step_q    <= 1'b0;
      code      <= 6'd0;
      wrap      <= 1'b0;
    end else begin
      cur_state <= nxt_state;
      cnt       <= cnt_nxt;
      step_q    <= step;
      code      <= code_nxt;
      wrap      <= wrap_nxt;
    end
  end

  assign state = cur_state;

endmodule

// File: tb/tb_char_sequencer.sv
// Self-checking bench for char_sequencer: directed scenarios followed by
// randomized traffic, all compared against a behavioural reference model.
module tb_char_sequencer;

  localparam int STEP_DIV  = 4;
  localparam int LAST_CODE = 41;

  logic       clk_2;
  logic       reset_n;
  logic       run;
  logic       dir;
  logic       step;
  logic       load;
  logic [5:0] load_code;
  logic [5:0] code;
  logic       wrap;
  logic [1:0] state;

  int n_checks;
  int n_fail;

  // Reference model: ring position, mode (0 idle, 1 running, 2 held),
  // RUN cycles elapsed in the current interval, previous button level.
  int m_code;
  int m_wrap;
  int m_state;
  int m_elapsed;
  int m_step_prev;
  int wrap_seen;

  char_sequencer #(.STEP_DIV(STEP_DIV), .LAST_CODE(LAST_CODE)) dut (
    .clk_2     (clk_2),
    .reset_n   (reset_n),
    .run       (run),
    .dir       (dir),
    .step      (step),
    .load      (load),
    .load_code (load_code),
    .code      (code),
    .wrap      (wrap),
    .state     (state)
  );

  // Clock and reset block
  initial begin
    clk_2 = 1'b0;
    forever #5 clk_2 = ~clk_2;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_code      = 0;
    m_wrap      = 0;
    m_state     = 0;
    m_elapsed   = 0;
    m_step_prev = 0;
  endtask

  // Apply one clock edge worth of the specification's rules.
  task automatic model_edge();
    bit adv;
    adv = 0;
    if (m_state == 1 && run) begin
      m_elapsed = m_elapsed + 1;
      if (m_elapsed == STEP_DIV) begin
        adv       = 1;
        m_elapsed = 0;
      end
    end else begin
      m_elapsed = 0;
    end
    if (m_state != 1 && step && !m_step_prev) adv = 1;
    m_wrap = 0;
    if (load) begin
      m_code    = (int'(load_code) > LAST_CODE) ? LAST_CODE : int'(load_code);
      m_elapsed = 0;
    end else if (adv) begin
      if (!dir) begin
        m_wrap = (m_code == LAST_CODE);
        m_code = (m_code + 1) % (LAST_CODE + 1);
      end else begin
        m_wrap = (m_code == 0);
        m_code = (m_code + LAST_CODE) % (LAST_CODE + 1);
      end
    end
    if (run) m_state = 1;
    else if (m_state != 0) m_state = 2;
    m_step_prev = step;
  endtask

  // Driver: one clock with model update and scoreboard compare 1 ns later.
  task automatic tick();
    @(posedge clk_2);
    model_edge();
    #1;
    check("code", 32'(code), 32'(m_code));
    check("wrap", 32'(wrap), 32'(m_wrap));
    check("state", 32'(state), 32'(m_state));
  endtask

  // Driver: reset pulse between edges; outputs must clear without a clock.
  task automatic async_reset();
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    check("rst_code", 32'(code), 32'd0);
    check("rst_wrap", 32'(wrap), 32'd0);
    check("rst_state", 32'(state), 32'd0);
    #1 reset_n = 1'b1;
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    reset_n   = 1'b0;
    run       = 1'b0;
    dir       = 1'b0;
    step      = 1'b0;
    load      = 1'b0;
    load_code = 6'd0;
    model_reset();
    #1;
    check("init_code", 32'(code), 32'd0);
    check("init_state", 32'(state), 32'd0);
    check("init_wrap", 32'(wrap), 32'd0);
    #11 reset_n = 1'b1;

    // Reset from RUN with code 17, then idle for 20 cycles.
    load = 1'b1; load_code = 6'd17;
    tick();
    load = 1'b0; run = 1'b1;
    repeat (3) tick();
    check("pre_reset_code", 32'(code), 32'd17);
    async_reset();
    run = 1'b0;
    repeat (20) tick();
    check("idle_code", 32'(code), 32'd0);

    // Auto up with wrap from 39.
    load = 1'b1; load_code = 6'd39;
    tick();
    load = 1'b0; dir = 1'b0; run = 1'b1;
    wrap_seen = 0;
    repeat (17) begin
      tick();
      wrap_seen += int'(wrap);
    end
    check("up_wrap_count", 32'(wrap_seen), 32'd1);
    check("up_final_code", 32'(code), 32'd1);

    // Auto down with wrap from 1, then a direction change mid-interval.
    run = 1'b0;
    tick();
    load = 1'b1; load_code = 6'd1;
    tick();
    load = 1'b0; dir = 1'b1; run = 1'b1;
    repeat (14) tick();
    dir = 1'b0;
    repeat (6) tick();

    // Manual step in HOLD, then step pulses during RUN.
    run = 1'b1;
    repeat (2) tick();
    run = 1'b0;
    tick();
    check("hold_state", 32'(state), 32'd2);
    step = 1'b1;
    repeat (5) tick();
    step = 1'b0;
    repeat (2) tick();
    run = 1'b1;
    repeat (3) begin
      step = 1'b1; tick();
      step = 1'b0; tick();
    end

    // Load clamp on the prescaler expiry edge.
    run = 1'b0;
    tick();
    load = 1'b1; load_code = 6'd0;
    tick();
    load = 1'b0; run = 1'b1; dir = 1'b0;
    tick();
    repeat (3) tick();
    load = 1'b1; load_code = 6'd63;
    tick();
    check("clamp_code", 32'(code), 32'd41);
    check("clamp_wrap", 32'(wrap), 32'd0);
    load = 1'b0;
    repeat (4) tick();
    check("post_clamp_code", 32'(code), 32'd0);
    check("post_clamp_wrap", 32'(wrap), 32'd1);

    // Async reset with code 30 and two cycles counted.
    load = 1'b1; load_code = 6'd30;
    tick();
    load = 1'b0;
    repeat (2) tick();
    check("mid_code", 32'(code), 32'd30);
    async_reset();
    run = 1'b1;
    tick();
    repeat (STEP_DIV) tick();
    check("resume_code", 32'(code), 32'd1);

    // Randomized traffic with occasional asynchronous resets.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 15) == 0) run = ~run;
      if ($urandom_range(0, 7) == 0) dir = ~dir;
      step      = ($urandom_range(0, 2) == 0);
      load      = ($urandom_range(0, 24) == 0);
      load_code = 6'($urandom_range(0, 63));
      tick();
      if ($urandom_range(0, 199) == 0) async_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
